// File: rtl/pacessor_core.sv
// pacessor_core: multi-cycle fetch/exec CPU with a wait-stated instruction fetch,
// Z/C flags, conditional jumps, HALT and a back-pressured output port.
//
// Ports
//   clk, rst_master_n        clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request (FETCH only), byte address = PC
//   imem_rdata/imem_valid    instruction word {op,f1,f2,f3} and its valid strobe
//   out_data/out_valid       OUT payload, held until out_ready
//   out_ready                sink accept
//   halted                   core stopped by HALT (leave via reset only)
//   illegal                  sticky unknown-opcode flag
module pacessor_core #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_master_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              illegal
);
  localparam int RI_W = $clog2(REG_N);

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] f1;
    logic [7:0] f2;
    logic [7:0] f3;
  } instr_t;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT, S_HALT} state_t;

  state_t                        state;
  instr_t                        ir;
  logic [REG_N-1:0][DATA_W-1:0]  regs;
  logic [ADDR_W-1:0]             pc;
  logic                          zf, cf;

  logic [RI_W-1:0]   rd, ra, rb;
  logic [DATA_W-1:0] a, b, imm, res;
  logic [DATA_W:0]   wide;          // MSB carries the C flag
  logic              alu_op, legal, take;
  logic [ADDR_W-1:0] pc_inc, tgt_raw, jtgt;
  logic              unused_fields;

  assign imem_addr = pc;
  assign rd        = ir.f1[RI_W-1:0];
  assign ra        = ir.f2[RI_W-1:0];
  assign rb        = ir.f3[RI_W-1:0];
  assign a         = regs[ra];
  assign b         = regs[rb];
  assign imm       = DATA_W'(ir.f3);
  assign pc_inc    = pc + ADDR_W'(4);
  assign tgt_raw   = ADDR_W'(ir.f3);
  assign jtgt      = tgt_raw & ~ADDR_W'(3);   // jump targets are word aligned
  assign res       = wide[DATA_W-1:0];
  // high field bits beyond the register index width are don't-care
  assign unused_fields = ^{ir.f1, ir.f2, ir.f3};

  always_comb begin
    wide   = '0;
    alu_op = 1'b0;
    legal  = 1'b1;
    take   = 1'b0;
    case (ir.op)
      8'h01: begin wide = {1'b0, a} + {1'b0, b}; alu_op = 1'b1; end
      8'h02: begin wide = {1'b0, a} - {1'b0, b}; alu_op = 1'b1; end  // MSB = borrow
      8'h03: begin wide = {1'b0, a & b}; alu_op = 1'b1; end
      8'h04: begin wide = {1'b0, a | b}; alu_op = 1'b1; end
      8'h05: begin wide = {1'b0, a ^ b}; alu_op = 1'b1; end
      8'h06: begin wide = {a, 1'b0}; alu_op = 1'b1; end
      8'h07: begin wide = {a[0], 1'b0, a[DATA_W-1:1]}; alu_op = 1'b1; end
      8'h00, 8'h10, 8'h1F, 8'hFF: ;
      8'h20: take = 1'b1;
      8'h21: take = zf;
      8'h22: take = cf;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) begin
      state     <= S_FETCH;
      ir        <= '0;
      regs      <= '0;
      pc        <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      imem_req  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // a valid strobe only counts while our request is actually out
          if (imem_req && imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_EXEC;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_EXEC: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          pc       <= take ? jtgt : pc_inc;
          if (!legal) illegal <= 1'b1;
          if (alu_op) begin
            regs[rd] <= res;
            zf       <= (res == '0);
            cf       <= wide[DATA_W];
          end
          case (ir.op)
            8'h10: regs[rd] <= imm;
            8'h1F: begin
              out_data  <= a;
              out_valid <= 1'b1;
              state     <= S_OUT;
              imem_req  <= 1'b0;
              pc        <= pc;          // advances only once the sink accepts
            end
            8'hFF: begin
              halted   <= 1'b1;
              state    <= S_HALT;
              imem_req <= 1'b0;
              pc       <= pc;
            end
            default: ;
          endcase
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc_inc;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_pacessor_core.sv
// Bench for pacessor_core: directed programs plus random programs, checked
// against an instruction-level reference model driven by fetch handshakes.
module tb_pacessor_core;
  logic        clk = 1'b0;
  logic        rst_master_n = 1'b0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halted, illegal;

  always #5 clk = ~clk;

  pacessor_core #(.DATA_W(8), .REG_N(16), .ADDR_W(6)) dut (
    .clk(clk), .rst_master_n(rst_master_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .illegal(illegal)
  );

  int checks = 0, failures = 0;
  int cyc = 0, first_out = -1;
  logic [31:0] mem [16];

  // reference model state
  int  m_r [16];
  bit  m_z, m_c, m_halt, m_ill;
  int  m_pc;
  int  exp_out [$];

  // environment knobs
  int  wait_n = 0, rdy_mode = 0, wcnt = 0;
  bit  in_fetch = 0;
  logic [5:0] fetch_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int f1, input int f2, input int f3);
    return {op[7:0], f1[7:0], f2[7:0], f3[7:0]};
  endfunction

  task automatic fill();
    for (int i = 0; i < 16; i++) mem[i] = ins('hFF, 0, 0, 0);
  endtask

  // Executes one instruction at ISA level.
  task automatic model_exec(input logic [31:0] w);
    int op, rd, ra, rb, f3, a, b, r, npc;
    bit fl;
    op = int'(w[31:24]); rd = int'(w[19:16]); ra = int'(w[11:8]);
    rb = int'(w[3:0]);   f3 = int'(w[7:0]);
    a = m_r[ra]; b = m_r[rb]; r = 0; fl = 0;
    npc = (m_pc + 4) % 64;
    case (op)
      'h00: ;
      'h01: begin r = a + b; m_c = (r > 255); fl = 1; end
      'h02: begin r = a - b; m_c = (a < b);  fl = 1; end
      'h03: begin r = a & b; m_c = 0; fl = 1; end
      'h04: begin r = a | b; m_c = 0; fl = 1; end
      'h05: begin r = a ^ b; m_c = 0; fl = 1; end
      'h06: begin r = a * 2; m_c = (a >= 128); fl = 1; end
      'h07: begin r = a / 2; m_c = (a % 2 == 1); fl = 1; end
      'h10: m_r[rd] = f3;
      'h1F: exp_out.push_back(a);
      'h20: npc = f3 & 'h3C;
      'h21: if (m_z) npc = f3 & 'h3C;
      'h22: if (m_c) npc = f3 & 'h3C;
      'hFF: begin m_halt = 1; npc = m_pc; end
      default: m_ill = 1;
    endcase
    if (fl) begin
      r = r & 255;
      m_r[rd] = r;
      m_z = (r == 0);
    end
    m_pc = npc;
  endtask

  // One clock: sample at negedge, check, then drive the memory and sink.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (out_valid && first_out < 0) first_out = cyc;
    if (imem_req) begin
      if (!in_fetch) begin
        in_fetch = 1; wcnt = 0; fetch_addr = imem_addr;
        chk("fetch_addr", imem_addr, m_pc);
        chk("illegal_at_fetch", illegal, m_ill);
        chk("halted_at_fetch", halted, 0);
      end else begin
        chk("addr_hold", imem_addr, fetch_addr);
      end
      if (wcnt >= wait_n) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr[5:2]];
        model_exec(imem_rdata);
        in_fetch = 0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      // outside FETCH the bus carries junk that must be ignored
      imem_valid = (halted || out_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
    if (out_valid) begin
      if (exp_out.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        chk("out_data", out_data, exp_out[0]);
        if (out_ready) void'(exp_out.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_master_n = 1'b0; imem_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_z = 0; m_c = 0; m_halt = 0; m_ill = 0; m_pc = 0;
    exp_out.delete();
    in_fetch = 0; wcnt = 0; cyc = 0; first_out = -1;
    rst_master_n = 1'b1;
    chk("req_before_edge", imem_req, 0);
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin step(); n++; end
    chk("out_seen", out_valid, 1);
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin step(); n++; end
    chk("halt_reached", halted, 1);
    chk("halt_req_low", imem_req, 0);
    chk("halt_pc", imem_addr, m_pc);
    chk("outs_drained", exp_out.size(), 0);
    chk("halt_illegal", illegal, m_ill);
    repeat (3) step();
    chk("pc_frozen", imem_addr, m_pc);
    chk("still_halted", halted, 1);
  endtask

  task automatic load_add_prog();
    fill();
    mem[0] = ins('h10, 0, 0, 5);
    mem[1] = ins('h10, 1, 0, 9);
    mem[2] = ins('h01, 2, 0, 1);
    mem[3] = ins('h1F, 0, 2, 0);
    mem[4] = ins('h21, 0, 0, 'h3C);   // Z=0: falls through
    mem[5] = ins('h22, 0, 0, 'h3C);   // C=0: falls through
    mem[6] = ins('hFF, 0, 0, 0);
  endtask

  initial begin
    int ops [15];
    int op, tgt;
    ops = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07,
            'h10, 'h10, 'h1F, 'h20, 'h21, 'h22, 'h3A};

    // reset, simple program, zero-wait timing
    load_add_prog(); wait_n = 0; rdy_mode = 0;
    do_reset();
    step();
    chk("t1_req_first_edge", imem_req, 1);
    chk("t1_addr_zero", imem_addr, 0);
    wait_out(50);
    chk("t2_out_data", out_data, 14);
    chk("t2_out_cycle", first_out, 9);
    run_to_halt(200);
    chk("t2_end_pc", imem_addr, 'h18);

    // three wait states per fetch: 5 cycles per instruction
    wait_n = 3;
    do_reset();
    wait_out(100);
    chk("t4_out_data", out_data, 14);
    chk("t4_out_cycle", first_out, 21);
    run_to_halt(400);
    chk("t4_end_pc", imem_addr, 'h18);

    // carry and zero from 0xFF+1, JC then JZ
    fill(); wait_n = 0;
    mem[0]  = ins('h10, 0, 0, 'hFF);
    mem[1]  = ins('h10, 1, 0, 1);
    mem[2]  = ins('h01, 2, 0, 1);
    mem[3]  = ins('h22, 0, 0, 'h20);
    mem[8]  = ins('h21, 0, 0, 'h28);
    mem[10] = ins('h1F, 0, 2, 0);
    mem[11] = ins('hFF, 0, 0, 0);
    do_reset();
    wait_out(100);
    chk("t3_out_zero", out_data, 0);
    run_to_halt(200);
    chk("t3_end_pc", imem_addr, 'h2C);

    // back-pressure on OUT
    load_add_prog(); rdy_mode = 2;
    do_reset();
    wait_out(50);
    repeat (4) begin
      step();
      chk("t5_valid_held", out_valid, 1);
      chk("t5_req_low", imem_req, 0);
      chk("t5_pc_frozen", imem_addr, 'h0C);
      chk("t5_data_stable", out_data, 14);
    end
    rdy_mode = 0;
    step();
    step();
    chk("t5_next_addr", imem_addr, 'h10);
    chk("t5_refetch", imem_req, 1);
    run_to_halt(200);

    // PC wrap 0x3C -> 0x00 with SHL setting C on the second pass
    fill();
    mem[0]  = ins('h22, 0, 0, 'h0C);
    mem[1]  = ins('h10, 5, 0, 'h80);
    mem[2]  = ins('h20, 0, 0, 'h3C);
    mem[3]  = ins('h1F, 0, 4, 0);
    mem[4]  = ins('hFF, 0, 0, 0);
    mem[15] = ins('h06, 4, 5, 0);
    do_reset();
    wait_out(100);
    chk("wrap_out", out_data, 0);
    run_to_halt(200);
    chk("wrap_end_pc", imem_addr, 'h10);

    // illegal opcode then HALT
    fill();
    mem[0] = ins('h3A, 1, 2, 3);
    do_reset();
    run_to_halt(50);
    chk("t6_illegal", illegal, 1);
    chk("t6_halted", halted, 1);

    // reset asserted while OUT is pending
    fill();
    mem[0] = ins('h10, 1, 0, 'h77);
    mem[1] = ins('h1F, 0, 1, 0);
    rdy_mode = 2;
    do_reset();
    wait_out(50);
    chk("t6_out_payload", out_data, 'h77);
    #2 rst_master_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_req", imem_req, 0);
    rdy_mode = 0;

    // random programs: forward-only jumps keep them terminating
    repeat (8) begin
      fill();
      for (int s = 0; s < 15; s++) begin
        op = ops[$urandom_range(0, 14)];
        if (op >= 'h20 && op <= 'h22) begin
          tgt = $urandom_range(s + 1, 15);
          mem[s] = ins(op, $urandom_range(0, 255), $urandom_range(0, 255),
                       ($urandom_range(0, 3) << 6) | (tgt << 2) | $urandom_range(0, 3));
        end else begin
          mem[s] = ins(op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      wait_n = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 1);
      do_reset();
      run_to_halt(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
